// File: rtl/if_stage_bp_if.sv
// Fetch-stage bundle: instruction bus, EX redirect/BHT-update inputs and IF/ID buffer outputs.
// master = fetch stage, slave = surrounding pipeline/memory.
interface if_stage_bp_if;
  logic        pipeline_en;
  logic [31:0] inst_rdata;
  logic        inst_resp;
  logic [31:0] inst_addr;
  logic        inst_read;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        bht_update;
  logic [31:0] bht_update_pc;
  logic        bht_update_taken;
  logic [31:0] ir_out;
  logic [31:0] pc_out;
  logic        pred_taken_out;
  logic        valid_out;

  modport master (
    input  pipeline_en, inst_rdata, inst_resp, redirect, redirect_pc,
           bht_update, bht_update_pc, bht_update_taken,
    output inst_addr, inst_read, ir_out, pc_out, pred_taken_out, valid_out
  );

  modport slave (
    output pipeline_en, inst_rdata, inst_resp, redirect, redirect_pc,
           bht_update, bht_update_pc, bht_update_taken,
    input  inst_addr, inst_read, ir_out, pc_out, pred_taken_out, valid_out
  );
endinterface

// File: rtl/if_stage_bp.sv
// Fetch stage with next-PC prediction: 2-bit-counter BHT when IF_BHT_EN is defined,
// static backward-taken/forward-not-taken otherwise. JAL is always predicted taken.
module if_stage_bp #(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h60,
  parameter logic [31:0] BUBBLE_IR   = 32'h0
) (
  input logic           clk,
  input logic           reset_n,
  if_stage_bp_if.master bus
);

  localparam int unsigned IdxW  = $clog2(BHT_ENTRIES);
  localparam logic [6:0]  OpBr  = 7'b1100011;
  localparam logic [6:0]  OpJal = 7'b1101111;
  localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pco_q, pco_d;
  logic        pred_q, pred_d;
  logic        valid_q, valid_d;

  logic [6:0]  opcode;
  logic [31:0] b_imm, j_imm;
  logic        br_taken;

  always_comb begin
    opcode = bus.inst_rdata[6:0];
    b_imm  = {{19{bus.inst_rdata[31]}}, bus.inst_rdata[31], bus.inst_rdata[7],
              bus.inst_rdata[30:25], bus.inst_rdata[11:8], 1'b0};
    j_imm  = {{11{bus.inst_rdata[31]}}, bus.inst_rdata[31], bus.inst_rdata[19:12],
              bus.inst_rdata[20], bus.inst_rdata[30:21], 1'b0};
  end

`ifdef IF_BHT_EN
  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [1:0]      bht_d [BHT_ENTRIES];
  logic [IdxW-1:0] look_idx, upd_idx;
  logic            unused_upd_pc;

  assign look_idx      = pc_q[IdxW+1:2];
  assign upd_idx       = bus.bht_update_pc[IdxW+1:2];
  assign unused_upd_pc = ^{bus.bht_update_pc[31:IdxW+2], bus.bht_update_pc[1:0]};
  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign br_taken      = bht_q[look_idx][1];

  always_comb begin
    bht_d = bht_q;
    if (bus.bht_update && bus.pipeline_en) begin
      if (bus.bht_update_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end
`else
  logic unused_bht;

  assign unused_bht = ^{bus.bht_update, bus.bht_update_pc, bus.bht_update_taken};
  assign br_taken   = b_imm[31];
`endif

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    pco_d   = pco_q;
    pred_d  = pred_q;
    valid_d = valid_q;
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc & AlignMask;
      ir_d    = BUBBLE_IR;
      pred_d  = 1'b0;
      valid_d = 1'b0;
    end else if (!bus.pipeline_en) begin
      pc_d = pc_q;
    end else if (!bus.inst_resp) begin
      ir_d    = BUBBLE_IR;
      pred_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      ir_d    = bus.inst_rdata;
      pco_d   = pc_q;
      valid_d = 1'b1;
      pred_d  = 1'b0;
      pc_d    = (pc_q + 32'd4) & AlignMask;
      if (opcode == OpBr) begin
        if (br_taken) begin
          pc_d   = (pc_q + b_imm) & AlignMask;
          pred_d = 1'b1;
        end
      end else if (opcode == OpJal) begin
        pc_d   = (pc_q + j_imm) & AlignMask;
        pred_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      ir_q    <= BUBBLE_IR;
      pco_q   <= 32'h0;
      pred_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pco_q   <= pco_d;
      pred_q  <= pred_d;
      valid_q <= valid_d;
    end
  end

  assign bus.inst_addr      = pc_q;
  assign bus.inst_read      = reset_n;
  assign bus.ir_out         = ir_q;
  assign bus.pc_out         = pco_q;
  assign bus.pred_taken_out = pred_q;
  assign bus.valid_out      = valid_q;

endmodule
